// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over valid/ready and shifts it out MSB first.
// Optional macro PISO_PARITY_EN appends an even-parity bit after the data bits (PARITY state).
//
//   state  | meaning
//   IDLE   | no frame in progress, ready for a word
//   SHIFT  | data bits on ser_out, MSB first, counter counts down to 0
//   PARITY | (PISO_PARITY_EN only) parity bit on ser_out, final bit of frame
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic par;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             xfer;

    assign cnt_zero = (cnt == '0);
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
`ifdef PISO_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (xfer) begin
                sreg <= in_data;
                cnt  <= CNT_LOAD;
`ifdef PISO_PARITY_EN
                par  <= ^in_data;
`endif
            end else if (state == SHIFT) begin
                sreg <= {sreg[WIDTH-2:0], 1'b0};
                if (!cnt_zero) cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (xfer) state_nxt = SHIFT;
            SHIFT: begin
                if (cnt_zero) begin
`ifdef PISO_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = xfer ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: state_nxt = xfer ? SHIFT : IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs depend only on registered state, so in_valid/in_data never reach the serial side combinationally.
    always_comb begin
        in_ready  = 1'b0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        ser_last  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            SHIFT: begin
                ser_out   = sreg[WIDTH-1];
                ser_valid = 1'b1;
                busy      = 1'b1;
`ifndef PISO_PARITY_EN
                ser_last  = cnt_zero;
                in_ready  = cnt_zero;
`endif
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                ser_out   = par;
                ser_valid = 1'b1;
                ser_last  = 1'b1;
                busy      = 1'b1;
                in_ready  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (default build, parity disabled): WIDTH=4 main instance
// plus a WIDTH=2 instance for the shortest-frame boundary.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready, ser_out, ser_valid, ser_last, busy;

    logic [1:0] in_data2;
    logic       in_valid2;
    logic       in_ready2, ser_out2, ser_valid2, ser_last2, busy2;

    logic [3:0] q;
    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .ser_last(ser_last), .busy(busy)
    );

    piso_serializer #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .ser_out(ser_out2), .ser_valid(ser_valid2),
        .ser_last(ser_last2), .busy(busy2)
    );

    // Downstream 4-stage SIPO receiving the serial link.
    always_ff @(posedge clk) q <= {q[2:0], ser_out};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input string tag, input logic o, input logic v, input logic l,
                            input logic r, input logic b);
        chk({tag, ".ser_out"},   32'(ser_out),   32'(o));
        chk({tag, ".ser_valid"}, 32'(ser_valid), 32'(v));
        chk({tag, ".ser_last"},  32'(ser_last),  32'(l));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(r));
        chk({tag, ".busy"},      32'(busy),      32'(b));
    endtask

    task automatic expect_w2(input string tag, input logic o, input logic v, input logic l,
                             input logic r, input logic b);
        chk({tag, ".ser_out"},   32'(ser_out2),   32'(o));
        chk({tag, ".ser_valid"}, 32'(ser_valid2), 32'(v));
        chk({tag, ".ser_last"},  32'(ser_last2),  32'(l));
        chk({tag, ".in_ready"},  32'(in_ready2),  32'(r));
        chk({tag, ".busy"},      32'(busy2),      32'(b));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 4'b0000;
        in_valid2 = 1'b0; in_data2 = 2'b00;

        // reset, then idle
        tick; expect_o("rst1", 0, 0, 0, 1, 0);
        tick; expect_o("rst2", 0, 0, 0, 1, 0);
        rst = 1'b0;
        tick; expect_o("idle", 0, 0, 0, 1, 0);
        expect_w2("w2idle", 0, 0, 0, 1, 0);

        // single frame 1011
        in_data = 4'b1011; in_valid = 1'b1;
        tick; in_valid = 1'b0; in_data = 4'b0000;
        expect_o("sf.b0", 1, 1, 0, 0, 1);
        tick; expect_o("sf.b1", 0, 1, 0, 0, 1);
        tick; expect_o("sf.b2", 1, 1, 0, 0, 1);
        tick; expect_o("sf.b3", 1, 1, 1, 1, 1);
        tick; expect_o("sf.end", 0, 0, 0, 1, 0);
        chk("sf.sipo", 32'(q), 32'h0000000b);

        // back-to-back 1011 then 0110 with in_valid held
        in_data = 4'b1011; in_valid = 1'b1;
        tick; in_data = 4'b0110;
        expect_o("bb.b0", 1, 1, 0, 0, 1);
        tick; expect_o("bb.b1", 0, 1, 0, 0, 1);
        tick; expect_o("bb.b2", 1, 1, 0, 0, 1);
        tick; expect_o("bb.b3", 1, 1, 1, 1, 1);
        tick; in_valid = 1'b0; in_data = 4'b0000;
        expect_o("bb.b4", 0, 1, 0, 0, 1);
        chk("bb.sipo1", 32'(q), 32'h0000000b);
        tick; expect_o("bb.b5", 1, 1, 0, 0, 1);
        tick; expect_o("bb.b6", 1, 1, 0, 0, 1);
        tick; expect_o("bb.b7", 0, 1, 1, 1, 1);
        tick; expect_o("bb.end", 0, 0, 0, 1, 0);
        chk("bb.sipo2", 32'(q), 32'h00000006);

        // busy overrun: 0011 offered during 1100 is held off until the last bit
        in_data = 4'b1100; in_valid = 1'b1;
        tick; in_data = 4'b0011;
        expect_o("ov.b0", 1, 1, 0, 0, 1);
        tick; expect_o("ov.b1", 1, 1, 0, 0, 1);
        tick; expect_o("ov.b2", 0, 1, 0, 0, 1);
        tick; expect_o("ov.b3", 0, 1, 1, 1, 1);
        tick; in_valid = 1'b0; in_data = 4'b0000;
        expect_o("ov.b4", 0, 1, 0, 0, 1);
        chk("ov.sipo1", 32'(q), 32'h0000000c);
        tick; expect_o("ov.b5", 0, 1, 0, 0, 1);
        tick; expect_o("ov.b6", 1, 1, 0, 0, 1);
        tick; expect_o("ov.b7", 1, 1, 1, 1, 1);
        tick; expect_o("ov.end", 0, 0, 0, 1, 0);
        chk("ov.sipo2", 32'(q), 32'h00000003);

        // reset mid-frame, word offered during reset is dropped
        in_data = 4'b1111; in_valid = 1'b1;
        tick; in_valid = 1'b0;
        expect_o("rm.b0", 1, 1, 0, 0, 1);
        tick; expect_o("rm.b1", 1, 1, 0, 0, 1);
        rst = 1'b1; in_valid = 1'b1; in_data = 4'b1001;
        tick; expect_o("rm.rst1", 0, 0, 0, 1, 0);
        tick; expect_o("rm.rst2", 0, 0, 0, 1, 0);
        rst = 1'b0; in_data = 4'b0101;
        tick; in_valid = 1'b0; in_data = 4'b0000;
        expect_o("rm.b0n", 0, 1, 0, 0, 1);
        tick; expect_o("rm.b1n", 1, 1, 0, 0, 1);
        tick; expect_o("rm.b2n", 0, 1, 0, 0, 1);
        tick; expect_o("rm.b3n", 1, 1, 1, 1, 1);
        tick; expect_o("rm.end", 0, 0, 0, 1, 0);
        chk("rm.sipo", 32'(q), 32'h00000005);

        // WIDTH=2 boundary: two-cycle frame
        in_data2 = 2'b10; in_valid2 = 1'b1;
        tick; in_valid2 = 1'b0; in_data2 = 2'b00;
        expect_w2("w2.b0", 1, 1, 0, 0, 1);
        tick; expect_w2("w2.b1", 0, 1, 1, 1, 1);
        tick; expect_w2("w2.end", 0, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
